pcie_bas_wr_arbiter: RTL
========================

// Module: pcie_bas_wr_arbiter
// PURPOSE
// Shares one PCIe BAS Avalon-MM burst-write master among NUM_REQ requesters
// (fpga2cpu packet/tail DMA engines, future cpu2fpga completion writers).
// Burst-aware round-robin: a grant is held until the whole burst (1..8 beats)
// is accepted, so beats of different bursts never interleave. Sits between
// the DMA engines and the PCIe hard-IP BAS port. Write-only; read is tied off.
// PARAMETERS
// NUM_REQ   2   number of requesters (2..8)
// IDX_W     1   $clog2(NUM_REQ), min 1
// PORTS
// clk                  in   1            clock
// rst                  in   1            sync reset, active-high
// req_address          in   NUM_REQ*64   per-requester address, packed, req i at [i*64+:64]
// req_byteenable       in   NUM_REQ*64   per-requester byteenable
// req_write            in   NUM_REQ      per-requester write strobe
// req_writedata        in   NUM_REQ*512  per-requester write data
// req_burstcount       in   NUM_REQ*4    per-requester burstcount; valid on first beat only
// req_waitrequest      out  NUM_REQ      per-requester waitrequest
// out_address          out  64           to pcie_bas_address
// out_byteenable       out  64           to pcie_bas_byteenable
// out_write            out  1            to pcie_bas_write
// out_writedata        out  512          to pcie_bas_writedata
// out_burstcount       out  4            to pcie_bas_burstcount
// out_read             out  1            constant 0
// out_waitrequest      in   1            from pcie_bas_waitrequest
// burst_err            out  1            sticky: a first beat carried burstcount 0 or >8
// stat_grant_cnt       out  NUM_REQ*32   bursts granted per requester (see CONFIGURATION)
// stat_wait_cnt        out  NUM_REQ*32   cycles req_write=1 && req_waitrequest=1
// BEHAVIOUR
// - Reset: state=IDLE, last_grant=NUM_REQ-1, beats_left=0, burst_err=0, stats=0.
//   req_waitrequest=all 1 during reset and in IDLE.
//   out_write=0 during reset and in IDLE.
// - States:
//   - IDLE: if any req_write, grant g = first i with req_write[i] scanning last_grant+1
//     upward, mod NUM_REQ. Register g and go to GRANT. Arbitration latency is 1 cycle.
//   - GRANT: out_* = combinational mux of requester g's signals.
//     - out_write = req_write[g].
//     - req_waitrequest[g] = out_waitrequest; all other bits = 1.
// - Beat accepted when out_write && !out_waitrequest.
//   - First beat: beats_left = burstcount-1. A burstcount of 0 or >8 is treated as 1
//     and sets burst_err.
//   - Later beats: beats_left-1. The requester drives burstcount 0; it is passed
//     through unchanged.
// - Burst complete (accepted beat with beats_left reaching 0): last_grant=g, IDLE next
//   cycle. Result: one dead cycle between bursts; the next owner is chosen in IDLE.
// - Requester deasserts write mid-burst (e.g. packet buffer empty): grant is held,
//   out_write=0, and no other requester is served until the burst finishes.
// - Simultaneous requests: round-robin only, no fixed priority. A requester
//   waits at most NUM_REQ-1 bursts.
// - Single requester active: bursts to it back to back with 1 idle cycle between.
// - Reset mid-burst: grant dropped immediately, out_write=0 next cycle. The partial
//   burst is abandoned; the requesters are reset by the same rst.
// - beats_left is 4 bits and never underflows. out_read is constant 0.
// CONFIGURATION
// - PCIE_ARB_STATS_EN defined: stat_grant_cnt[i] += 1 on each grant to i.
//   stat_wait_cnt[i] += 1 each cycle req_write[i] && req_waitrequest[i].
//   Both are 32-bit, wrapping, cleared by rst.
// - PCIE_ARB_STATS_EN undefined: stat ports are present, driven constant 0, no counter logic.
// TESTING
// 1. Req0 single 1-beat burst, out_waitrequest=0 -> out_write at cycle 2.
//    req_waitrequest[0]=0 that cycle; IDLE after.
// 2. Req0 and req1 both issue 8-beat bursts from reset -> req0's 8 beats, 1 idle
//    cycle, then req1's 8 beats; no interleave.
// 3. Req1 holds an 8-beat burst; out_waitrequest=1 on beats 3-5 -> beat data and
//    address held stable, exactly 8 accepts, req0 blocked throughout.
// 4. Req0 drops write after beat 2 of 4 for 5 cycles while req1 requests -> grant
//    stays 0, out_write=0, req0 finishes, then req1 granted.
// 5. First beat with burstcount=0 -> single-beat burst, burst_err=1 until rst.
// 6. PCIE_ARB_STATS_EN, NUM_REQ=3, all three requesting 1-beat bursts continuously
//    for 30 cycles -> grants in order 0,1,2,0..., and stat_grant_cnt equal ±1 across requesters.

Source files
------------

// File: rtl/pcie_bas_wr_arbiter.sv
// pcie_bas_wr_arbiter: burst-aware round-robin arbiter that shares one PCIe BAS
// Avalon-MM burst-write master among NUM_REQ requesters. A grant is held until
// every beat of the burst has been accepted, so bursts never interleave. After
// each burst there is one idle cycle, during which the next owner is chosen.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   req_*              packed per-requester Avalon-MM write masters (req i at
//                      [i*W +: W]); req_waitrequest is all ones unless granted
//   out_*              merged master towards the PCIe BAS port; out_read = 0
//   burst_err          sticky: a first beat carried burstcount 0 or > 8
//   stat_grant_cnt     bursts granted per requester (32-bit each, wrapping)
//   stat_wait_cnt      cycles each requester was stalled with write high
//
// Optional feature: define PCIE_ARB_STATS_EN to build the statistics counters.
// Without it the stat ports are driven to zero and no counter logic exists.
module pcie_bas_wr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ*64-1:0]  req_address,
    input  logic [NUM_REQ*64-1:0]  req_byteenable,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [NUM_REQ*512-1:0] req_writedata,
    input  logic [NUM_REQ*4-1:0]   req_burstcount,
    output logic [NUM_REQ-1:0]     req_waitrequest,
    output logic [63:0]            out_address,
    output logic [63:0]            out_byteenable,
    output logic                   out_write,
    output logic [511:0]           out_writedata,
    output logic [3:0]             out_burstcount,
    output logic                   out_read,
    input  logic                   out_waitrequest,
    output logic                   burst_err,
    output logic [NUM_REQ*32-1:0]  stat_grant_cnt,
    output logic [NUM_REQ*32-1:0]  stat_wait_cnt
);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] r_last;
    logic [3:0]       r_beats;
    logic             r_first;
    logic             r_burst_err;

    logic [63:0]      w_addr [NUM_REQ];
    logic [63:0]      w_be   [NUM_REQ];
    logic [511:0]     w_data [NUM_REQ];
    logic [3:0]       w_bc   [NUM_REQ];

    logic             w_any;
    logic             w_found;
    logic [IDX_W-1:0] w_pick;
    logic             w_granted;
    logic             w_accept;
    logic [3:0]       w_bc_g;
    logic             w_bc_bad;
    logic [3:0]       w_left_next;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_addr[i] = req_address[i*64 +: 64];
            w_be[i]   = req_byteenable[i*64 +: 64];
            w_data[i] = req_writedata[i*512 +: 512];
            w_bc[i]   = req_burstcount[i*4 +: 4];
        end
    end

    // Round-robin pick: first requester with write high, starting just after
    // the last owner and wrapping around.
    always_comb begin
        w_any   = |req_write;
        w_found = 1'b0;
        w_pick  = r_last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && req_write[(int'(r_last) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_pick  = IDX_W'((int'(r_last) + k) % NUM_REQ);
            end
        end
    end

    // Reset masks the grant at once so nothing leaks out during rst.
    assign w_granted = (r_state == S_GRANT) && !rst;

    assign out_address    = w_addr[r_grant];
    assign out_byteenable = w_be[r_grant];
    assign out_writedata  = w_data[r_grant];
    assign out_burstcount = w_bc[r_grant];
    assign out_write      = w_granted && req_write[r_grant];
    assign out_read       = 1'b0;
    assign burst_err      = r_burst_err;

    always_comb begin
        req_waitrequest = '1;
        if (w_granted) begin
            req_waitrequest[r_grant] = out_waitrequest;
        end
    end

    assign w_accept = out_write && !out_waitrequest;
    assign w_bc_g   = w_bc[r_grant];
    assign w_bc_bad = (w_bc_g == 4'd0) || (w_bc_g > 4'd8);

    // An illegal first-beat burstcount degrades to a single-beat burst.
    always_comb begin
        if (r_first) begin
            w_left_next = w_bc_bad ? 4'd0 : w_bc_g - 4'd1;
        end else begin
            w_left_next = (r_beats == 4'd0) ? 4'd0 : r_beats - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_grant     <= IDX_W'(NUM_REQ - 1);
            r_last      <= IDX_W'(NUM_REQ - 1);
            r_beats     <= 4'd0;
            r_first     <= 1'b0;
            r_burst_err <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_first <= 1'b1;
                        r_beats <= 4'd0;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_accept) begin
                        r_first <= 1'b0;
                        r_beats <= w_left_next;
                        if (r_first && w_bc_bad) begin
                            r_burst_err <= 1'b1;
                        end
                        if (w_left_next == 4'd0) begin
                            r_last  <= r_grant;
                            r_state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

`ifdef PCIE_ARB_STATS_EN
    logic        w_idle_grant;
    logic [31:0] r_gcnt [NUM_REQ];
    logic [31:0] r_wcnt [NUM_REQ];

    assign w_idle_grant = (r_state == S_IDLE) && w_any;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                r_gcnt[i] <= 32'd0;
                r_wcnt[i] <= 32'd0;
            end else begin
                if (w_idle_grant && (w_pick == IDX_W'(i))) begin
                    r_gcnt[i] <= r_gcnt[i] + 32'd1;
                end
                if (req_write[i] && req_waitrequest[i]) begin
                    r_wcnt[i] <= r_wcnt[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_grant_cnt[i*32 +: 32] = r_gcnt[i];
            stat_wait_cnt[i*32 +: 32]  = r_wcnt[i];
        end
    end
`else
    assign stat_grant_cnt = '0;
    assign stat_wait_cnt  = '0;
`endif

endmodule
